// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: width helpers shared by the FIFO family.
// Pointer width is clamped to at least one bit.
package sync_fifo_pkg;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_thresh_if.sv
// sync_fifo_thresh_if: producer/consumer bundle for sync_fifo_thresh.
// The master side drives requests; the slave side is the FIFO.
interface sync_fifo_thresh_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) ();

  logic                      w_en;
  logic                      r_en;
  logic [DATA_WIDTH-1:0]     data_in;
  logic [DATA_WIDTH-1:0]     data_out;
  logic                      full;
  logic                      empty;
  logic                      almost_full;
  logic                      almost_empty;
  logic [cnt_w(DEPTH)-1:0]   count;
  logic                      overflow;
  logic                      underflow;

  modport master (
    output w_en, r_en, data_in,
    input  data_out, full, empty,
    input  almost_full, almost_empty,
    input  count, overflow, underflow
  );

  modport slave (
    input  w_en, r_en, data_in,
    output data_out, full, empty,
    output almost_full, almost_empty,
    output count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: register array, one write port, one async read port.
// Contents are intentionally not reset.
module sync_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AW         = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_thresh.sv
// sync_fifo_thresh: single-clock FIFO with count, thresholds, error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_thresh
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input logic clk,
  input logic rst,
  sync_fifo_thresh_if.slave bus
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count_q, count_nxt;
  logic                  full_q, empty_q;
  logic                  af_q, ae_q;
  logic                  ovf_q, unf_q;
  logic                  wr_ok, rd_ok;
  logic [DATA_WIDTH-1:0] rdata;

  // A full FIFO still takes a write when a read frees a slot.
  assign rd_ok = bus.r_en & ~empty_q;
  assign wr_ok = bus.w_en & (~full_q | rd_ok);

  always_comb begin
    count_nxt = count_q;
    unique case (1'b1)
      wr_ok & ~rd_ok: count_nxt = count_q + 1'b1;
      rd_ok & ~wr_ok: count_nxt = count_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_nxt;
      full_q  <= count_nxt == CW'(DEPTH);
      empty_q <= count_nxt == '0;
      af_q    <= count_nxt >= CW'(AF_LEVEL);
      ae_q    <= count_nxt <= CW'(AE_LEVEL);
      ovf_q   <= bus.w_en & ~wr_ok;
      unf_q   <= bus.r_en & ~rd_ok;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (PW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (bus.data_in),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.data_out = rdata;
`else
  logic [DATA_WIDTH-1:0] dout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        dout_q <= '0;
    else if (rd_ok) dout_q <= rdata;
  end

  assign bus.data_out = dout_q;
`endif

  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_thresh.sv
// tb_sync_fifo_thresh: directed vector table plus corner-case sequences.
// Flags in the table are packed {full,empty,af,ae,ovf,unf}.
module tb_sync_fifo_thresh;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sync_fifo_thresh_if #(.DATA_WIDTH(8), .DEPTH(8)) bus ();

  sync_fifo_thresh #(
    .DATA_WIDTH (8),
    .DEPTH      (8),
    .AF_LEVEL   (6),
    .AE_LEVEL   (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit         w;
    bit         r;
    logic [7:0] d;
    int         c;
    bit   [5:0] fl;
    bit         chk;
    logic [7:0] q;
  } vec_t;

  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(bit w, bit r, logic [7:0] d, int c,
                              bit [5:0] fl, bit chk, logic [7:0] q);
    vec_t v;
    v.w = w; v.r = r; v.d = d; v.c = c;
    v.fl = fl; v.chk = chk; v.q = q;
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // Called at a negedge; returns the word popped by this cycle.
  // qv says whether q is meaningful for the build's read mode.
  task automatic cycle(input bit w, input bit r, input logic [7:0] d,
                       output logic [7:0] q, output bit qv);
    bus.w_en    = w;
    bus.r_en    = r;
    bus.data_in = d;
    #1;
`ifdef SYNC_FIFO_FWFT_EN
    q  = bus.data_out;
    qv = r & ~bus.empty;
`endif
    @(posedge clk);
    @(negedge clk);
`ifndef SYNC_FIFO_FWFT_EN
    q  = bus.data_out;
    qv = 1'b1;
`endif
    bus.w_en = 1'b0;
    bus.r_en = 1'b0;
  endtask

  task automatic chk_flags(input string n, input int c, input bit [5:0] fl);
    chk({n, " count"}, 32'(bus.count), 32'(c));
    chk({n, " full"}, 32'(bus.full), 32'(fl[5]));
    chk({n, " empty"}, 32'(bus.empty), 32'(fl[4]));
    chk({n, " almost_full"}, 32'(bus.almost_full), 32'(fl[3]));
    chk({n, " almost_empty"}, 32'(bus.almost_empty), 32'(fl[2]));
    chk({n, " overflow"}, 32'(bus.overflow), 32'(fl[1]));
    chk({n, " underflow"}, 32'(bus.underflow), 32'(fl[0]));
  endtask

  initial begin
    logic [7:0] q;
    bit         qv;

    // fill 0x10..0x17, then overflow and idle
    tbl.push_back(mk(1, 0, 8'h10, 1, 6'b000100, 0, 8'h00));
    tbl.push_back(mk(1, 0, 8'h11, 2, 6'b000100, 0, 8'h00));
    tbl.push_back(mk(1, 0, 8'h12, 3, 6'b000000, 0, 8'h00));
    tbl.push_back(mk(1, 0, 8'h13, 4, 6'b000000, 0, 8'h00));
    tbl.push_back(mk(1, 0, 8'h14, 5, 6'b000000, 0, 8'h00));
    tbl.push_back(mk(1, 0, 8'h15, 6, 6'b001000, 0, 8'h00));
    tbl.push_back(mk(1, 0, 8'h16, 7, 6'b001000, 0, 8'h00));
    tbl.push_back(mk(1, 0, 8'h17, 8, 6'b101000, 0, 8'h00));
    tbl.push_back(mk(1, 0, 8'hFF, 8, 6'b101010, 0, 8'h00));
    tbl.push_back(mk(0, 0, 8'h00, 8, 6'b101000, 0, 8'h00));
    // drain, then underflow holding the last word
    tbl.push_back(mk(0, 1, 8'h00, 7, 6'b001000, 1, 8'h10));
    tbl.push_back(mk(0, 1, 8'h00, 6, 6'b001000, 1, 8'h11));
    tbl.push_back(mk(0, 1, 8'h00, 5, 6'b000000, 1, 8'h12));
    tbl.push_back(mk(0, 1, 8'h00, 4, 6'b000000, 1, 8'h13));
    tbl.push_back(mk(0, 1, 8'h00, 3, 6'b000000, 1, 8'h14));
    tbl.push_back(mk(0, 1, 8'h00, 2, 6'b000100, 1, 8'h15));
    tbl.push_back(mk(0, 1, 8'h00, 1, 6'b000100, 1, 8'h16));
    tbl.push_back(mk(0, 1, 8'h00, 0, 6'b010100, 1, 8'h17));
    tbl.push_back(mk(0, 1, 8'h00, 0, 6'b010101, 1, 8'h17));
    // write+read on empty: read rejected, write accepted
    tbl.push_back(mk(1, 1, 8'h55, 1, 6'b000101, 1, 8'h17));
    tbl.push_back(mk(0, 1, 8'h00, 0, 6'b010100, 1, 8'h55));
    // refill 0x30..0x37
    tbl.push_back(mk(1, 0, 8'h30, 1, 6'b000100, 0, 8'h00));
    tbl.push_back(mk(1, 0, 8'h31, 2, 6'b000100, 0, 8'h00));
    tbl.push_back(mk(1, 0, 8'h32, 3, 6'b000000, 0, 8'h00));
    tbl.push_back(mk(1, 0, 8'h33, 4, 6'b000000, 0, 8'h00));
    tbl.push_back(mk(1, 0, 8'h34, 5, 6'b000000, 0, 8'h00));
    tbl.push_back(mk(1, 0, 8'h35, 6, 6'b001000, 0, 8'h00));
    tbl.push_back(mk(1, 0, 8'h36, 7, 6'b001000, 0, 8'h00));
    tbl.push_back(mk(1, 0, 8'h37, 8, 6'b101000, 0, 8'h00));
    // write+read on full: both accepted, no overflow
    tbl.push_back(mk(1, 1, 8'hAA, 8, 6'b101000, 1, 8'h30));
    tbl.push_back(mk(0, 1, 8'h00, 7, 6'b001000, 1, 8'h31));
    tbl.push_back(mk(0, 1, 8'h00, 6, 6'b001000, 1, 8'h32));
    tbl.push_back(mk(0, 1, 8'h00, 5, 6'b000000, 1, 8'h33));
    tbl.push_back(mk(0, 1, 8'h00, 4, 6'b000000, 1, 8'h34));
    tbl.push_back(mk(0, 1, 8'h00, 3, 6'b000000, 1, 8'h35));
    tbl.push_back(mk(0, 1, 8'h00, 2, 6'b000100, 1, 8'h36));
    tbl.push_back(mk(0, 1, 8'h00, 1, 6'b000100, 1, 8'h37));
    tbl.push_back(mk(0, 1, 8'h00, 0, 6'b010100, 1, 8'hAA));
    // underflow repeats while the condition persists
    tbl.push_back(mk(0, 1, 8'h00, 0, 6'b010101, 1, 8'hAA));
    tbl.push_back(mk(0, 1, 8'h00, 0, 6'b010101, 1, 8'hAA));

    rst         = 1'b1;
    bus.w_en    = 1'b0;
    bus.r_en    = 1'b0;
    bus.data_in = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_flags("reset", 0, 6'b010100);
`ifndef SYNC_FIFO_FWFT_EN
    chk("reset data_out", 32'(bus.data_out), 32'h0);
`endif
    @(negedge clk);

    foreach (tbl[i]) begin
      cycle(tbl[i].w, tbl[i].r, tbl[i].d, q, qv);
      chk_flags($sformatf("row%0d", i), tbl[i].c, tbl[i].fl);
      if (tbl[i].chk && qv)
        chk($sformatf("row%0d data_out", i), 32'(q), 32'(tbl[i].q));
    end

    // wrap-around: pointers pass the end of the array twice
    for (int i = 0; i < 20; i++) begin
      cycle(1, 0, 8'(i), q, qv);
      chk($sformatf("wrap%0d count_w", i), 32'(bus.count), 32'd1);
      cycle(0, 1, 8'h00, q, qv);
      chk($sformatf("wrap%0d count_r", i), 32'(bus.count), 32'd0);
      if (qv) chk($sformatf("wrap%0d data", i), 32'(q), 32'(i));
    end

    // asynchronous reset with five words stored
    for (int i = 0; i < 5; i++) cycle(1, 0, 8'h60 + 8'(i), q, qv);
    chk("pre-reset count", 32'(bus.count), 32'd5);
    bus.r_en = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk_flags("midreset", 0, 6'b010100);
`ifndef SYNC_FIFO_FWFT_EN
    chk("midreset data_out", 32'(bus.data_out), 32'h0);
`endif
    bus.r_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_flags("post-reset", 0, 6'b010100);
    @(negedge clk);
    cycle(1, 0, 8'h3C, q, qv);
    chk_flags("after 3C", 1, 6'b000100);
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft 3C visible", 32'(bus.data_out), 32'h3C);
`endif
    cycle(0, 1, 8'h00, q, qv);
    if (qv) chk("read 3C", 32'(q), 32'h3C);
    chk_flags("after read 3C", 0, 6'b010100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
